alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational 32-bit ALU.
- WIDTH-bit operands with a 4-bit command: the original eight ops plus unsigned compare, three shifts and an optional multi-cycle multiply.
- Valid/ready handshake on input and output; one operation in flight at a time.
- Sits between the register-file read stage and writeback in the multi-cycle CPU datapath.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 4.
- SHAMT_W (localparam), log2(WIDTH), shift-amount width taken from operandB.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands/command valid
- in_ready  output  1  block can accept an operation
- command  input  4  operation select (encoding below)
- operandA  input  WIDTH  first operand
- operandB  input  WIDTH  second operand / shift amount
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  registered result
- carryout  output  1  carry out of MSB (ADD/SUB only)
- zero  output  1  result == 0 (ADD/SUB only)
- overflow  output  1  signed overflow (ADD/SUB only)
- err  output  1  illegal command

Behaviour:
- Command encoding:
  - 0 ADD, 1 SUB, 2 XOR, 3 SLT (signed), 4 AND, 5 NAND, 6 NOR, 7 OR.
  - 8 SLTU, 9 SLL, 10 SRL, 11 SRA, 12 MUL.
  - 13-15 illegal.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- Accept occurs on an edge with in_valid && in_ready; operands and command are captured into internal registers at that edge.
- Transitions:
  - IDLE, on accept of a non-MUL command: compute, register result/flags, go to DONE. out_valid is high in the cycle after accept (latency 1).
  - IDLE, on accept of MUL: go to BUSY and clear the counter.
  - BUSY: shift-add one multiplier bit per cycle for WIDTH cycles, then go to DONE. out_valid rises WIDTH+1 edges after the accept edge.
  - DONE: hold result/flags stable while out_ready is low. On an edge with out_ready high, go to IDLE; in_ready is high the next cycle.
- Arithmetic:
  - SUB is two's complement via A + ~B + 1. carryout is the raw MSB carry, so no borrow gives 1.
  - overflow = carry into MSB XOR carry out of MSB.
  - carryout, zero and overflow are 0 for every command except ADD/SUB.
  - SLT: result = {0..., (A <s B)}, correct even when A-B overflows.
  - SLTU: result = {0..., (A <u B)}.
  - Shifts use operandB[SHAMT_W-1:0] only; upper B bits are ignored. SRA replicates A[WIDTH-1].
  - MUL: result = low WIDTH bits of A*B (sign-agnostic). Flags are 0.
- Illegal commands: accepted normally with latency 1; result 0, all flags 0, err 1. err is 0 for every legal command.
- Reset (synchronous, any state, including mid-BUSY):
  - Next state IDLE; counter cleared; the in-flight op is discarded.
  - result, carryout, zero, overflow, err = 0; out_valid = 0; in_ready = 1 after the reset edge.
- in_valid asserted while in_ready is low is ignored; the source must hold it.
- Outputs change only when entering DONE or on reset.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined: MUL (12) is implemented as above, with the BUSY state and a log2(WIDTH)+1-bit counter.
- Undefined: no BUSY state or multiplier logic. Command 12 is treated as illegal: latency 1, result 0, err 1.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> one cycle after accept: result 0x80000000, overflow 1, carryout 0, zero 0, err 0.
- SUB 0x00000005 - 0x00000005 -> result 0, zero 1, carryout 1, overflow 0. Then XOR 0xFFFF0000 ^ 0x0F0F0F0F -> result 0xF0F00F0F, all flags 0.
- SLT A=0xFFFFFFFF, B=1 -> result 1. SLTU with the same operands -> result 0. SLT A=0x80000000, B=0x7FFFFFFF -> result 1.
- SRA A=0x80000000, B=0x00000024 (low 5 bits = 4) -> 0xF8000000. SRL same -> 0x08000000. SLL A=1, B=31 -> 0x80000000.
- MUL 0x00010000 * 0x00010001 (macro defined) -> result 0x00010000 with out_valid rising 33 edges after accept. Hold out_ready low 3 cycles -> result stable and in_ready 0, then IDLE the cycle after out_ready=1. Macro undefined -> err 1, result 0, latency 1.
- Reset asserted 10 cycles into MUL -> next cycle out_valid 0, in_ready 1, result 0. Command 14 -> err 1, result 0, flags 0.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered, handshaked ALU for the multi-cycle datapath: one operation in flight at a time.
// Define ALU_PIPE_MUL_EN to build the shift-add multiplier (command 12); otherwise command 12 is illegal.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       command,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_SUB  = 4'd1;
  localparam logic [3:0] CMD_XOR  = 4'd2;
  localparam logic [3:0] CMD_SLT  = 4'd3;
  localparam logic [3:0] CMD_AND  = 4'd4;
  localparam logic [3:0] CMD_NAND = 4'd5;
  localparam logic [3:0] CMD_NOR  = 4'd6;
  localparam logic [3:0] CMD_OR   = 4'd7;
  localparam logic [3:0] CMD_SLTU = 4'd8;
  localparam logic [3:0] CMD_SLL  = 4'd9;
  localparam logic [3:0] CMD_SRL  = 4'd10;
  localparam logic [3:0] CMD_SRA  = 4'd11;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] CMD_MUL  = 4'd12;
  localparam int         CNT_W    = SHAMT_W + 1;
`endif

  // Handshake: an op is taken on a rising edge with in_valid && in_ready, and a result
  // leaves on a rising edge with out_valid && out_ready; both sides hold until that edge.
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_carryout;
  logic             r_zero;
  logic             r_overflow;
  logic             r_err;

`ifdef ALU_PIPE_MUL_EN
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
`endif

  logic               w_accept;
  logic               w_sub;
  logic [WIDTH-1:0]   w_bx;
  logic [WIDTH:0]     w_sum;
  logic               w_cin_msb;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_res;
  logic               w_cout;
  logic               w_zero;
  logic               w_ovf;
  logic               w_err;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign dbg_state = r_state;
  assign result    = r_result;
  assign carryout  = r_carryout;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign err       = r_err;

  assign w_accept = in_valid && in_ready;

  // SUB reuses the adder as A + ~B + 1; the carry into the MSB is recovered from the sum bit.
  assign w_sub     = (command == CMD_SUB);
  assign w_bx      = w_sub ? ~operandB : operandB;
  assign w_sum     = {1'b0, operandA} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
  assign w_cin_msb = w_sum[WIDTH-1] ^ operandA[WIDTH-1] ^ w_bx[WIDTH-1];
  assign w_shamt   = operandB[SHAMT_W-1:0];

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_zero = 1'b0;
    w_ovf  = 1'b0;
    w_err  = 1'b0;
    case (command)
      CMD_ADD, CMD_SUB: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_zero = (w_sum[WIDTH-1:0] == '0);
        w_ovf  = w_cin_msb ^ w_sum[WIDTH];
      end
      CMD_XOR:  w_res = operandA ^ operandB;
      CMD_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
      CMD_AND:  w_res = operandA & operandB;
      CMD_NAND: w_res = ~(operandA & operandB);
      CMD_NOR:  w_res = ~(operandA | operandB);
      CMD_OR:   w_res = operandA | operandB;
      CMD_SLTU: w_res = {{(WIDTH-1){1'b0}}, (operandA < operandB)};
      CMD_SLL:  w_res = operandA << w_shamt;
      CMD_SRL:  w_res = operandA >> w_shamt;
      CMD_SRA:  w_res = $unsigned($signed(operandA) >>> w_shamt);
      default:  w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_result   <= '0;
      r_carryout <= 1'b0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      r_cnt      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
`ifdef ALU_PIPE_MUL_EN
            if (command == CMD_MUL) begin
              r_state  <= BUSY;
              r_cnt    <= '0;
              r_acc    <= '0;
              r_mcand  <= operandA;
              r_mplier <= operandB;
            end else
`endif
            begin
              r_state    <= DONE;
              r_result   <= w_res;
              r_carryout <= w_cout;
              r_zero     <= w_zero;
              r_overflow <= w_ovf;
              r_err      <= w_err;
            end
          end
        end
`ifdef ALU_PIPE_MUL_EN
        // WIDTH shift-add steps, then one more edge publishes the product.
        BUSY: begin
          if (r_cnt == CNT_W'(WIDTH)) begin
            r_state    <= DONE;
            r_result   <= r_acc;
            r_carryout <= 1'b0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
`endif
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes hand-computed expectations, a negedge monitor
// pops and compares on every out_valid rise and checks the result holds while stalled.
module tb_alu_pipe;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   command;
  logic [W-1:0] operandA;
  logic [W-1:0] operandB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carryout;
  logic         zero;
  logic         overflow;
  logic         err;
  logic [1:0]   dbg_state;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .command   (command),
    .operandA  (operandA),
    .operandB  (operandB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryout  (carryout),
    .zero      (zero),
    .overflow  (overflow),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Expected word layout: {err, overflow, zero, carryout, result}
`ifdef ALU_PIPE_MUL_EN
  localparam logic [W+3:0] EXP_M1   = {4'b0000, 32'h0001_0000};
  localparam logic [W+3:0] EXP_M2   = {4'b0000, 32'h0000_0001};
  localparam logic [W+3:0] EXP_M3   = {4'b0000, 32'h0000_002A};
  localparam int           LAT_M    = W + 1;
  localparam bit           PUSH_RST = 1'b0;
`else
  localparam logic [W+3:0] EXP_M1   = {4'b1000, 32'h0};
  localparam logic [W+3:0] EXP_M2   = {4'b1000, 32'h0};
  localparam logic [W+3:0] EXP_M3   = {4'b1000, 32'h0};
  localparam int           LAT_M    = 0;
  localparam bit           PUSH_RST = 1'b1;
`endif

  logic [W+3:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];
  int           id_q[$];

  int           n_cmp;
  int           n_fail;
  int           cyc;
  int           op_id;
  bit           prev_valid;
  logic [W+3:0] held;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: present an op, hold it until accepted, record expectation against the accept edge
  task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W+3:0] exp, input int lat, input bit push);
    bit ok;
    @(posedge clk);
    #1;
    command  = cmd;
    operandA = a;
    operandB = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout cmd %0d: got in_ready 0, expected 1", cmd);
    end else if (push) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      acc_q.push_back(cyc + 1);
      id_q.push_back(op_id);
    end
    op_id++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W+3:0] act;
    logic [W+3:0] e;
    int           lat;
    int           acc;
    int           id;
    act = {err, overflow, zero, carryout, result};
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got %h, expected no result", act);
        end else begin
          e   = exp_q.pop_front();
          lat = lat_q.pop_front();
          acc = acc_q.pop_front();
          id  = id_q.pop_front();
          check($sformatf("op%0d_value", id), 64'(act), 64'(e));
          check($sformatf("op%0d_latency", id), 64'(cyc - acc), 64'(lat));
        end
        held = act;
      end else if (out_valid) begin
        check("hold_stable", 64'(act), 64'(held));
        check("hold_in_ready", 64'(in_ready), 64'(0));
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    bit ok;
    n_cmp      = 0;
    n_fail     = 0;
    cyc        = 0;
    op_id      = 0;
    prev_valid = 1'b0;
    held       = '0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    command    = '0;
    operandA   = '0;
    operandB   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'({err, overflow, zero, carryout, result}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));

    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, {4'b0100, 32'h8000_0000}, 0, 1);
    issue(4'd1, 32'h0000_0005, 32'h0000_0005, {4'b0011, 32'h0000_0000}, 0, 1);
    issue(4'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, {4'b0000, 32'hF0F0_0F0F}, 0, 1);
    issue(4'd3, 32'hFFFF_FFFF, 32'h0000_0001, {4'b0000, 32'h0000_0001}, 0, 1);
    issue(4'd8, 32'hFFFF_FFFF, 32'h0000_0001, {4'b0000, 32'h0000_0000}, 0, 1);
    issue(4'd3, 32'h8000_0000, 32'h7FFF_FFFF, {4'b0000, 32'h0000_0001}, 0, 1);
    issue(4'd11, 32'h8000_0000, 32'h0000_0024, {4'b0000, 32'hF800_0000}, 0, 1);
    issue(4'd10, 32'h8000_0000, 32'h0000_0024, {4'b0000, 32'h0800_0000}, 0, 1);
    issue(4'd9, 32'h0000_0001, 32'h0000_001F, {4'b0000, 32'h8000_0000}, 0, 1);
    issue(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, {4'b0000, 32'hF000_F000}, 0, 1);
    issue(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, {4'b0000, 32'h0FFF_0FFF}, 0, 1);
    issue(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, {4'b0000, 32'h000F_000F}, 0, 1);
    issue(4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, {4'b0000, 32'hFFF0_FFF0}, 0, 1);
    issue(4'd1, 32'h0000_0000, 32'h0000_0001, {4'b0000, 32'hFFFF_FFFF}, 0, 1);
    issue(4'd1, 32'h8000_0000, 32'h0000_0001, {4'b0101, 32'h7FFF_FFFF}, 0, 1);
    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, {4'b0011, 32'h0000_0000}, 0, 1);
    issue(4'd8, 32'h0000_0001, 32'hFFFF_FFFF, {4'b0000, 32'h0000_0001}, 0, 1);
    drain();

    // stalled consumer: result must hold for three cycles, then the block returns to IDLE
    out_ready = 1'b0;
    issue(4'd12, 32'h0001_0000, 32'h0001_0001, EXP_M1, LAT_M, 1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("mul_out_valid_seen", 64'(ok), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 64'(in_ready), 64'(1));
    check("release_out_valid", 64'(out_valid), 64'(0));

    issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, EXP_M2, LAT_M, 1);
    issue(4'd12, 32'h0000_0007, 32'h0000_0006, EXP_M3, LAT_M, 1);
    drain();

    // reset ten cycles after accepting a multiply discards it
    out_ready = 1'b0;
    issue(4'd12, 32'h0000_0003, 32'h0000_0005, EXP_M1 & '0 | EXP_M3, LAT_M, PUSH_RST);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_result", 64'({err, overflow, zero, carryout, result}), 64'(0));
    out_ready = 1'b1;

    issue(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, {4'b1000, 32'h0}, 0, 1);
    issue(4'd13, 32'hFFFF_FFFF, 32'h0000_0001, {4'b1000, 32'h0}, 0, 1);
    issue(4'd15, 32'h0000_0000, 32'h0000_0000, {4'b1000, 32'h0}, 0, 1);
    issue(4'd0, 32'h0000_0002, 32'h0000_0003, {4'b0000, 32'h0000_0005}, 0, 1);
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
